alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Execute-stage front end feeding the 32-bit `alu` (inputs `A`, `B`, `ALUop`). Accepts decoded instruction fields from the decode stage over a valid/ready handshake, translates opcode/funct into the 3-bit ALU operation code, and builds both operands (register or extended immediate). Holds one issued entry plus one skid entry, so throughput is one instruction per cycle under backpressure. Outputs are registered and drive the ALU directly.

## Interface
- `DATA_WIDTH`, 32, operand width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous; discards all held entries.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `in_opcode`  in  6  instruction[31:26].
- `in_funct`  in  6  instruction[5:0]; used only when opcode is 0.
- `in_rs_data`  in  32  rs register value.
- `in_rt_data`  in  32  rt register value.
- `in_imm`  in  16  instruction[15:0].
- `in_dest`  in  5  destination register tag, passed through unchanged.
- `out_valid`  out  1  issued entry is present.
- `out_ready`  in  1  consumer takes the entry this cycle.
- `out_A`, `out_B`  out  32  ALU operands.
- `out_ALUop`  out  3  ALU operation code.
- `out_dest`  out  5  tag of the issued entry.
- `out_illegal`  out  1  the issued entry has an unsupported encoding.

## Operation
- ALUop codes: ADD 000, SUB 001, SLT 010, SLTU 011, XOR 100, NOR 101, OR 110, AND 111.
- R-type (opcode 000000): A=rs, B=rt. Funct mapping: 100001→ADD, 100011→SUB, 101010→SLT, 101011→SLTU, 100100→AND, 100101→OR, 100110→XOR, 100111→NOR.
- I-type: A=rs. Opcode mapping:
  - 001001, 001010, 001011: ADD, SLT, SLTU with B = sign-extended imm.
  - 001100, 001101, 001110: AND, OR, XOR with B = zero-extended imm.
  - 001111 (lui): A=0, B={imm,16'h0}, OR.
  - 100011 and 101011 (lw/sw): ADD with B = sign-extended imm.
- Any other opcode or funct: ADD, A=0, B=0, illegal=1. The entry is still issued in order.
- Storage has two slots, main (drives `out_*`) and skid. State is encoded as EMPTY (no valid), ONE (main valid), FULL (main and skid valid).
- `in_ready` = not FULL, taken from a register and not combinational on `out_ready`. An accept happens when `in_valid & in_ready`. A drain happens when `out_valid & out_ready`.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept without drain → FULL; the new entry goes to skid.
  - ONE + accept and drain → ONE; the new entry replaces main.
  - ONE + drain only → EMPTY.
  - FULL + drain → ONE; skid moves to main. No accept is possible in FULL.
- Order is strictly FIFO. An entry is never dropped or duplicated.
- `flush` → EMPTY on the next edge. It has priority over an accept and a drain in the same cycle; the entry offered in that cycle is discarded.

## Timing
- Reset: state EMPTY. `out_valid`=0, `in_ready`=1, and `out_A`, `out_B`, `out_ALUop`, `out_dest`, `out_illegal` all 0.
- Latency: an accept at edge N gives `out_valid`=1 with the decoded fields after edge N, when the stage was EMPTY or draining.
- Stall: while `out_valid & ~out_ready`, every `out_*` holds stable.
- `in_ready` falls in the cycle after the skid slot fills. It rises in the cycle after a drain from FULL.
- Reset asserted mid-operation clears both slots immediately. Nothing is presented after release until a new accept.

## Test plan
- Reset, then accept addu (rs=5, rt=7, funct 100001) with `out_ready`=1 → next cycle `out_valid`=1, ALUop=000, A=5, B=7, illegal=0.
- addiu with imm=16'hFFFF → B=32'hFFFF_FFFF. ori with imm=16'hFFFF → B=32'h0000_FFFF, ALUop=110. lui with imm=16'h1234 → A=0, B=32'h1234_0000, ALUop=110.
- Hold `out_ready`=0 and offer three back-to-back instructions → the first two are accepted, `in_ready`=0 before the third, outputs stay stable. Then raise `out_ready` → the three drain in order, one per cycle.
- Continuous `in_valid` and `out_ready` for 16 cycles → 16 issues, `in_ready` always 1.
- Assert `flush` while FULL and `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and the offered entry never appears.
- Opcode 000010 (j) → ALUop=000, A=B=0, illegal=1. Funct 000000 under opcode 0 → illegal=1.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between the decode stage, the ALU issue stage and the ALU.
// The issue stage takes the slave side; whoever feeds and drains it takes master.
interface alu_issue_stage_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [5:0]            in_opcode;
   logic [5:0]            in_funct;
   logic [DATA_WIDTH-1:0] in_rs_data;
   logic [DATA_WIDTH-1:0] in_rt_data;
   logic [15:0]           in_imm;
   logic [4:0]            in_dest;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_A;
   logic [DATA_WIDTH-1:0] out_B;
   logic [2:0]            out_ALUop;
   logic [4:0]            out_dest;
   logic                  out_illegal;

   modport master (
      output flush, in_valid, in_opcode, in_funct, in_rs_data, in_rt_data,
             in_imm, in_dest, out_ready,
      input  in_ready, out_valid, out_A, out_B, out_ALUop, out_dest, out_illegal
   );

   modport slave (
      input  flush, in_valid, in_opcode, in_funct, in_rs_data, in_rt_data,
             in_imm, in_dest, out_ready,
      output in_ready, out_valid, out_A, out_B, out_ALUop, out_dest, out_illegal
   );
endinterface

// File: rtl/alu_issue_stage.sv
// Execute-stage front end: decodes opcode/funct into an ALU operation, builds
// both operands and holds them in a main + skid pair for full-rate backpressure.
module alu_issue_stage #(
   parameter int DATA_WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_issue_stage_if.slave bus
);

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_SLT  = 3'b010,
      OP_SLTU = 3'b011,
      OP_XOR  = 3'b100,
      OP_NOR  = 3'b101,
      OP_OR   = 3'b110,
      OP_AND  = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
      alu_op_e               op;
      logic [4:0]            dest;
      logic                  illegal;
   } entry_t;

   entry_t dec;
   entry_t main_q;
   entry_t skid_q;
   state_e state_q;
   logic   out_valid_q;
   logic   in_ready_q;

   logic [DATA_WIDTH-1:0] imm_sext;
   logic [DATA_WIDTH-1:0] imm_zext;
   logic [DATA_WIDTH-1:0] imm_upper;
   logic                  legal;
   logic                  accept;
   logic                  drain;

   assign imm_sext  = {{(DATA_WIDTH-16){bus.in_imm[15]}}, bus.in_imm};
   assign imm_zext  = {{(DATA_WIDTH-16){1'b0}}, bus.in_imm};
   assign imm_upper = {bus.in_imm, {(DATA_WIDTH-16){1'b0}}};

   // NOTE: every field gets a default before the case so no path leaves a
   // variable unassigned, which would otherwise infer a latch.
   always_comb begin
      legal       = 1'b1;
      dec.a       = bus.in_rs_data;
      dec.b       = bus.in_rt_data;
      dec.op      = OP_ADD;
      dec.dest    = bus.in_dest;
      dec.illegal = 1'b0;

      case (bus.in_opcode)
         6'b000000: begin
            case (bus.in_funct)
               6'b100001: dec.op = OP_ADD;
               6'b100011: dec.op = OP_SUB;
               6'b101010: dec.op = OP_SLT;
               6'b101011: dec.op = OP_SLTU;
               6'b100100: dec.op = OP_AND;
               6'b100101: dec.op = OP_OR;
               6'b100110: dec.op = OP_XOR;
               6'b100111: dec.op = OP_NOR;
               default:   legal  = 1'b0;
            endcase
         end
         6'b001001: begin dec.b = imm_sext; dec.op = OP_ADD;  end
         6'b001010: begin dec.b = imm_sext; dec.op = OP_SLT;  end
         6'b001011: begin dec.b = imm_sext; dec.op = OP_SLTU; end
         6'b001100: begin dec.b = imm_zext; dec.op = OP_AND;  end
         6'b001101: begin dec.b = imm_zext; dec.op = OP_OR;   end
         6'b001110: begin dec.b = imm_zext; dec.op = OP_XOR;  end
         6'b001111: begin
            dec.a  = '0;
            dec.b  = imm_upper;
            dec.op = OP_OR;
         end
         6'b100011, 6'b101011: begin dec.b = imm_sext; dec.op = OP_ADD; end
         default: legal = 1'b0;
      endcase

      // Unsupported encodings still flow through in order as a harmless 0+0.
      if (!legal) begin
         dec.a       = '0;
         dec.b       = '0;
         dec.op      = OP_ADD;
         dec.illegal = 1'b1;
      end
   end

   // in_ready comes from a flop, so accept never depends on out_ready.
   assign accept = bus.in_valid & in_ready_q;
   assign drain  = out_valid_q & bus.out_ready;

   // NOTE: the entry slots are reset along with the control state so the ALU
   // operands read as zero out of reset instead of X.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         main_q      <= '0;
         skid_q      <= '0;
      end else if (bus.flush) begin
         state_q     <= EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_q      <= dec;
                  state_q     <= ONE;
                  out_valid_q <= 1'b1;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  main_q <= dec;
               end else if (accept) begin
                  skid_q     <= dec;
                  state_q    <= FULL;
                  in_ready_q <= 1'b0;
               end else if (drain) begin
                  state_q     <= EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            FULL: begin
               if (drain) begin
                  main_q     <= skid_q;
                  state_q    <= ONE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_A       = main_q.a;
   assign bus.out_B       = main_q.b;
   assign bus.out_ALUop   = main_q.op;
   assign bus.out_dest    = main_q.dest;
   assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed steps plus random traffic
// compared against a two-deep FIFO model with a table-style decoder.
module tb_alu_issue_stage;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [4:0]  dest;
      logic        illegal;
   } ref_t;

   logic clk;
   logic rst_n;

   alu_issue_stage_if #(.DATA_WIDTH(32)) bus ();

   alu_issue_stage #(.DATA_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int accepts = 0;
   ref_t exp_q[$];
   logic [4:0] drained[$];

   logic [5:0] op_tbl [14] = '{6'd0, 6'd0, 6'd0, 6'd9, 6'd10, 6'd11, 6'd12,
                               6'd13, 6'd14, 6'd15, 6'd35, 6'd43, 6'd2, 6'd63};
   logic [5:0] fn_tbl [10] = '{6'h21, 6'h23, 6'h2a, 6'h2b, 6'h24, 6'h25,
                               6'h26, 6'h27, 6'h00, 6'h3f};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference decoder written from the mnemonic table, not from the RTL.
   function automatic ref_t ref_decode(input logic [5:0] opc, input logic [5:0] fn,
                                       input logic [31:0] rs, input logic [31:0] rt,
                                       input logic [15:0] imm, input logic [4:0] dest);
      ref_t r;
      logic [31:0] se;
      logic [31:0] ze;
      se = {{16{imm[15]}}, imm};
      ze = {16'h0000, imm};
      r.dest = dest;
      r.illegal = 1'b0;
      r.a = rs;
      r.b = rt;
      r.op = 3'd0;
      if (opc == 6'd0) begin
         if      (fn == 6'h21) r.op = 3'd0;
         else if (fn == 6'h23) r.op = 3'd1;
         else if (fn == 6'h2a) r.op = 3'd2;
         else if (fn == 6'h2b) r.op = 3'd3;
         else if (fn == 6'h24) r.op = 3'd7;
         else if (fn == 6'h25) r.op = 3'd6;
         else if (fn == 6'h26) r.op = 3'd4;
         else if (fn == 6'h27) r.op = 3'd5;
         else r.illegal = 1'b1;
      end else if (opc == 6'd9 || opc == 6'd35 || opc == 6'd43) begin
         r.b = se; r.op = 3'd0;
      end else if (opc == 6'd10) begin
         r.b = se; r.op = 3'd2;
      end else if (opc == 6'd11) begin
         r.b = se; r.op = 3'd3;
      end else if (opc == 6'd12) begin
         r.b = ze; r.op = 3'd7;
      end else if (opc == 6'd13) begin
         r.b = ze; r.op = 3'd6;
      end else if (opc == 6'd14) begin
         r.b = ze; r.op = 3'd4;
      end else if (opc == 6'd15) begin
         r.a = 32'd0; r.b = {imm, 16'h0000}; r.op = 3'd6;
      end else begin
         r.illegal = 1'b1;
      end
      if (r.illegal) begin
         r.a = 32'd0; r.b = 32'd0; r.op = 3'd0;
      end
      return r;
   endfunction

   task automatic drive(input logic v, input logic [5:0] opc, input logic [5:0] fn,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [15:0] imm, input logic [4:0] dest);
      bus.in_valid   = v;
      bus.in_opcode  = opc;
      bus.in_funct   = fn;
      bus.in_rs_data = rs;
      bus.in_rt_data = rt;
      bus.in_imm     = imm;
      bus.in_dest    = dest;
   endtask

   task automatic drive_random(input logic v);
      drive(v, op_tbl[$urandom_range(13)], fn_tbl[$urandom_range(9)], $urandom,
            $urandom, 16'($urandom), 5'($urandom));
   endtask

   task automatic compare_model();
      check("in_ready", bus.in_ready, exp_q.size() < 2);
      check("out_valid", bus.out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
         check("out_A", bus.out_A, exp_q[0].a);
         check("out_B", bus.out_B, exp_q[0].b);
         check("out_ALUop", bus.out_ALUop, exp_q[0].op);
         check("out_dest", bus.out_dest, exp_q[0].dest);
         check("out_illegal", bus.out_illegal, exp_q[0].illegal);
      end
   endtask

   // One clock: predict from pre-edge inputs, advance the model, check #1 later.
   task automatic step();
      bit   acc;
      bit   drn;
      bit   fl;
      ref_t e;
      acc = bus.in_valid && (exp_q.size() < 2);
      drn = bus.out_ready && (exp_q.size() > 0);
      fl  = bus.flush;
      e   = ref_decode(bus.in_opcode, bus.in_funct, bus.in_rs_data, bus.in_rt_data,
                       bus.in_imm, bus.in_dest);
      @(posedge clk);
      if (fl) begin
         exp_q.delete();
      end else begin
         if (drn) drained.push_back(exp_q.pop_front().dest);
         if (acc) begin
            exp_q.push_back(e);
            accepts++;
         end
      end
      #1;
      compare_model();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"}, bus.out_valid, 1'b0);
      check({tag, "_in_ready"}, bus.in_ready, 1'b1);
      check({tag, "_out_A"}, bus.out_A, 32'd0);
      check({tag, "_out_B"}, bus.out_B, 32'd0);
      check({tag, "_out_ALUop"}, bus.out_ALUop, 3'd0);
      check({tag, "_out_dest"}, bus.out_dest, 5'd0);
      check({tag, "_out_illegal"}, bus.out_illegal, 1'b0);
   endtask

   initial begin
      int a0;
      int d0;
      logic [31:0] held_a;
      logic [4:0]  held_dest;

      rst_n = 1'b0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      drive(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 16'd0, 5'd0);
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // addu rs=5 rt=7
      bus.out_ready = 1'b1;
      drive(1'b1, 6'b000000, 6'b100001, 32'd5, 32'd7, 16'h0000, 5'd1);
      step();
      check("addu_valid", bus.out_valid, 1'b1);
      check("addu_op", bus.out_ALUop, 3'b000);
      check("addu_A", bus.out_A, 32'd5);
      check("addu_B", bus.out_B, 32'd7);
      check("addu_illegal", bus.out_illegal, 1'b0);

      drive(1'b1, 6'b001001, 6'd0, 32'd9, 32'd0, 16'hFFFF, 5'd2);
      step();
      check("addiu_B", bus.out_B, 32'hFFFF_FFFF);
      drive(1'b1, 6'b001101, 6'd0, 32'd9, 32'd0, 16'hFFFF, 5'd3);
      step();
      check("ori_B", bus.out_B, 32'h0000_FFFF);
      check("ori_op", bus.out_ALUop, 3'b110);
      drive(1'b1, 6'b001111, 6'd0, 32'hDEAD_BEEF, 32'd0, 16'h1234, 5'd4);
      step();
      check("lui_A", bus.out_A, 32'd0);
      check("lui_B", bus.out_B, 32'h1234_0000);
      check("lui_op", bus.out_ALUop, 3'b110);

      // Illegal encodings
      drive(1'b1, 6'b000010, 6'd0, 32'd11, 32'd12, 16'h5555, 5'd5);
      step();
      check("j_op", bus.out_ALUop, 3'b000);
      check("j_A", bus.out_A, 32'd0);
      check("j_B", bus.out_B, 32'd0);
      check("j_illegal", bus.out_illegal, 1'b1);
      drive(1'b1, 6'b000000, 6'b000000, 32'd11, 32'd12, 16'h0, 5'd6);
      step();
      check("funct0_illegal", bus.out_illegal, 1'b1);
      drive(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 16'd0, 5'd0);
      step();

      // Backpressure: three back-to-back offers with out_ready low
      drained.delete();
      bus.out_ready = 1'b0;
      drive(1'b1, 6'b000000, 6'b100011, 32'd100, 32'd1, 16'h0, 5'd21);
      step();
      held_a = bus.out_A;
      held_dest = bus.out_dest;
      drive(1'b1, 6'b000000, 6'b100101, 32'd200, 32'd2, 16'h0, 5'd22);
      step();
      check("bp_in_ready_low", bus.in_ready, 1'b0);
      drive(1'b1, 6'b001100, 6'd0, 32'd300, 32'd0, 16'h00F0, 5'd23);
      step();
      check("bp_stall_A", bus.out_A, held_a);
      check("bp_stall_dest", bus.out_dest, held_dest);
      step();
      check("bp_stall_dest2", bus.out_dest, 5'd21);
      bus.out_ready = 1'b1;
      step();
      step();
      drive(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 16'd0, 5'd0);
      step();
      step();
      check("bp_drain_count", drained.size(), 3);
      if (drained.size() == 3) begin
         check("bp_order0", drained[0], 5'd21);
         check("bp_order1", drained[1], 5'd22);
         check("bp_order2", drained[2], 5'd23);
      end

      // Sixteen cycles of continuous flow
      a0 = accepts;
      d0 = drained.size();
      for (int i = 0; i < 16; i++) begin
         drive_random(1'b1);
         step();
         check("stream_in_ready", bus.in_ready, 1'b1);
      end
      drive(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 16'd0, 5'd0);
      step();
      check("stream_accepts", accepts - a0, 16);
      check("stream_issues", drained.size() - d0, 16);

      // Flush while FULL with an offer pending
      bus.out_ready = 1'b0;
      drive(1'b1, 6'b001001, 6'd0, 32'd1, 32'd0, 16'd1, 5'd7);
      step();
      drive(1'b1, 6'b001001, 6'd0, 32'd2, 32'd0, 16'd2, 5'd8);
      step();
      check("flush_full", bus.in_ready, 1'b0);
      d0 = drained.size();
      bus.flush = 1'b1;
      drive(1'b1, 6'b001001, 6'd0, 32'd3, 32'd0, 16'd3, 5'd31);
      step();
      check("flush_out_valid", bus.out_valid, 1'b0);
      check("flush_in_ready", bus.in_ready, 1'b1);
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 16'd0, 5'd0);
      repeat (3) step();
      check("flush_nothing_drained", drained.size() - d0, 0);

      // Randomized traffic with occasional flush
      for (int i = 0; i < 400; i++) begin
         drive_random($urandom_range(99) < 70);
         bus.out_ready = ($urandom_range(99) < 60);
         bus.flush = ($urandom_range(99) < 3);
         step();
      end
      bus.flush = 1'b0;

      // Reset mid-operation while FULL
      bus.out_ready = 1'b0;
      drive(1'b1, 6'b001101, 6'd0, 32'd77, 32'd0, 16'h00AA, 5'd9);
      step();
      step();
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check_reset_state("midrst");
      @(negedge clk);
      drive(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 16'd0, 5'd0);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (2) step();
      check("midrst_idle_valid", bus.out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
